// File: rtl/cascade_count_capture_pkg.sv
// Shared definitions for the cascaded counter extension and its capture path.
package cascade_count_capture_pkg;

   localparam int LO_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } cap_state_t;

   function automatic int cap_w(input int hi_w);
      return hi_w + LO_W;
   endfunction

endpackage

// File: rtl/cascade_count_capture_hi_count_stage.sv
// Loadable high-order count stage driven by the carry of the stage below.
// Chainable: co feeds the ci of a further stage under the same rules.
module hi_count_stage #(
   parameter int HI_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld_n,
   input  logic            en,
   input  logic            ci,
   input  logic [HI_W-1:0] d,
   output logic [HI_W-1:0] q,
   output logic            co,
   output logic            wrap_evt
);

   logic inc;

   assign inc      = en & ci;
   assign co       = inc & (&q);
   // a load overrides the increment, so loading all ones never counts as a wrap
   assign wrap_evt = co & ld_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        q <= '0;
      else if (!ld_n) q <= d;
      else if (inc)   q <= q + HI_W'(1);
   end

endmodule

// File: rtl/cascade_count_capture.sv
// High-order extension of a 4-bit 161-style counter with snapshot capture
// over valid/ready and sticky lost-capture / wrap flags.
module cascade_count_capture
   import cascade_count_capture_pkg::*;
#(
   parameter int HI_W = 4
) (
   input  logic                 CP,
   input  logic                 CR,
   input  logic [LO_W-1:0]      Q_LO,
   input  logic                 CO_LO,
   input  logic                 EN,
   input  logic                 LD,
   input  logic [HI_W-1:0]      D_HI,
   input  logic                 CAP_REQ,
   input  logic                 CAP_RDY,
   input  logic                 OVF_CLR,
   output logic [HI_W-1:0]      Q_HI,
   output logic                 CO_HI,
   output logic [HI_W+LO_W-1:0] CAP_DATA,
   output logic                 CAP_VLD,
   output logic                 LOST,
   output logic                 WRAP
);

   localparam int CAP_W = cap_w(HI_W);

   cap_state_t       state;
   logic             wrap_evt;
   logic             lost_evt;
   logic [CAP_W-1:0] count;

   hi_count_stage #(.HI_W(HI_W)) u_hi (
      .clk      (CP),
      .rst      (CR),
      .ld_n     (LD),
      .en       (EN),
      .ci       (CO_LO),
      .d        (D_HI),
      .q        (Q_HI),
      .co       (CO_HI),
      .wrap_evt (wrap_evt)
   );

   assign count    = {Q_HI, Q_LO};
   assign lost_evt = (state == HOLD) & CAP_REQ & ~CAP_RDY;
   assign CAP_VLD  = (state == HOLD);

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state    <= IDLE;
         CAP_DATA <= '0;
      end else begin
         case (state)
            IDLE: if (CAP_REQ) begin
               CAP_DATA <= count;
               state    <= HOLD;
            end
            HOLD: if (CAP_RDY) begin
               // back-to-back request reloads in the handshake cycle, no bubble
               if (CAP_REQ) CAP_DATA <= count;
               else         state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // set events win over a simultaneous clear
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         LOST <= 1'b0;
         WRAP <= 1'b0;
      end else begin
         LOST <= (LOST & ~OVF_CLR) | lost_evt;
         WRAP <= (WRAP & ~OVF_CLR) | wrap_evt;
      end
   end

endmodule
